// File: rtl/xor_load_sequencer_pkg.sv
// Shared types and default constants for the XOR core load sequencer.
// The optional idle timeout inside a payload is enabled by XOR_LOAD_TIMEOUT_EN.
package xor_load_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_END
    } state_e;

    // Selects which load flag is driven for the payload in progress.
    typedef enum logic {
        FRAME_KEY,
        FRAME_MSG
    } frame_e;

    localparam logic [7:0] HDR_KEY_DEF = 8'h4B;
    localparam logic [7:0] HDR_MSG_DEF = 8'h4D;

endpackage

// File: rtl/xor_load_sequencer_if.sv
// Host byte handshake plus serial/control lines towards the XOR core.
// master = host/bench side, slave = sequencer side.
interface xor_load_sequencer_if;

    logic [7:0] iByte;
    logic       iByte_valid;
    logic       oByte_ready;
    logic       oSerial_out;
    logic       oEn;
    logic       oLoad_key;
    logic       oLoad_msg;
    logic       oBusy;
    logic       oDone;
    logic       oError;

    modport master (
        output iByte, iByte_valid,
        input  oByte_ready, oSerial_out, oEn, oLoad_key, oLoad_msg,
               oBusy, oDone, oError
    );

    modport slave (
        input  iByte, iByte_valid,
        output oByte_ready, oSerial_out, oEn, oLoad_key, oLoad_msg,
               oBusy, oDone, oError
    );

endinterface

// File: rtl/xor_load_sequencer_byte_shifter.sv
// Byte-to-bit serialiser: one-byte holding register in front of an 8-bit
// MSB-first shift register with a 3-bit bit counter.
module xor_byte_shifter (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       flush_i,
    input  logic [7:0] byte_i,
    input  logic       take_i,
    output logic       ready_o,
    output logic       bit_o,
    output logic       bit_valid_o,
    output logic       byte_done_o
);

    logic [7:0] hold_q, hold_d;
    logic       hold_v_q, hold_v_d;
    logic [7:0] sh_q, sh_d;
    logic       sh_v_q, sh_v_d;
    logic [2:0] cnt_q, cnt_d;
    logic       last_bit;

    assign last_bit    = sh_v_q && (cnt_q == 3'd7);
    assign ready_o     = !hold_v_q;
    assign bit_o       = sh_v_q && sh_q[7];
    assign bit_valid_o = sh_v_q;
    assign byte_done_o = last_bit;

    // Next state: shift, refill from holding, or bypass an incoming byte
    // straight into an idle shifter so a fresh stream starts one cycle sooner.
    always_comb begin
        hold_d   = hold_q;
        hold_v_d = hold_v_q;
        sh_d     = sh_q;
        sh_v_d   = sh_v_q;
        cnt_d    = cnt_q;
        if (sh_v_q && !last_bit) begin
            sh_d  = {sh_q[6:0], 1'b0};
            cnt_d = cnt_q + 3'd1;
            if (take_i) begin
                hold_d   = byte_i;
                hold_v_d = 1'b1;
            end
        end else if (hold_v_q) begin
            sh_d     = hold_q;
            sh_v_d   = 1'b1;
            cnt_d    = 3'd0;
            hold_v_d = 1'b0;
        end else if (take_i) begin
            sh_d   = byte_i;
            sh_v_d = 1'b1;
            cnt_d  = 3'd0;
        end else begin
            sh_d   = '0;
            sh_v_d = 1'b0;
            cnt_d  = 3'd0;
        end
        if (flush_i) begin
            hold_d   = '0;
            hold_v_d = 1'b0;
            sh_d     = '0;
            sh_v_d   = 1'b0;
            cnt_d    = 3'd0;
        end
    end

    // Register update with synchronous reset.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            hold_q   <= '0;
            hold_v_q <= 1'b0;
            sh_q     <= '0;
            sh_v_q   <= 1'b0;
            cnt_q    <= 3'd0;
        end else begin
            hold_q   <= hold_d;
            hold_v_q <= hold_v_d;
            sh_q     <= sh_d;
            sh_v_q   <= sh_v_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/xor_load_sequencer.sv
// Upstream load sequencer of the XOR encryption core: decodes a header byte,
// streams KEY_BYTES or MSG_BYTES payload bytes MSB-first with load flags held.
// Define XOR_LOAD_TIMEOUT_EN to abort a payload after TIMEOUT_CYCLES idle cycles.
module xor_load_sequencer
    import xor_load_pkg::*;
#(
    parameter int unsigned KEY_BYTES      = 4,
    parameter int unsigned MSG_BYTES      = 64,
    parameter logic [7:0]  HDR_KEY        = HDR_KEY_DEF,
    parameter logic [7:0]  HDR_MSG        = HDR_MSG_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                 iClk,
    input  logic                 iRst,
    xor_load_sequencer_if.slave  bus
);

    localparam int unsigned CW = $clog2(MSG_BYTES + 1);
    localparam logic [CW-1:0] KEY_N = CW'(KEY_BYTES);
    localparam logic [CW-1:0] MSG_N = CW'(MSG_BYTES);

    if (KEY_BYTES < 1 || KEY_BYTES > MSG_BYTES || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("xor_load_sequencer: invalid payload length or timeout parameters");
    end

    state_e        state_q;
    frame_e        frame_q;
    logic [CW-1:0] acc_q;
    logic          load_key_q, load_msg_q, busy_q, done_q, error_q;

    logic [CW-1:0] target;
    logic          remaining;
    logic          ready;
    logic          take;
    logic          sh_ready, sh_bit, sh_bit_valid, sh_byte_done;
    logic          frame_last;
    logic          timeout;

    assign target    = (frame_q == FRAME_KEY) ? KEY_N : MSG_N;
    assign remaining = acc_q < target;
    assign ready     = !iRst && ((state_q == ST_IDLE) ||
                                 ((state_q == ST_LOAD) && sh_ready && remaining));
    assign take      = bus.iByte_valid && ready;
    // Final bit of the payload: every byte accepted and nothing left queued.
    assign frame_last = (state_q == ST_LOAD) && sh_byte_done && !remaining && sh_ready;

`ifdef XOR_LOAD_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt_q;

    assign timeout = (state_q == ST_LOAD) && !take && remaining &&
                     (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    // Idle-cycle counter while payload bytes are still outstanding.
    always_ff @(posedge iClk) begin
        if (iRst || state_q != ST_LOAD || take) begin
            to_cnt_q <= '0;
        end else if (remaining) begin
            to_cnt_q <= to_cnt_q + TW'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    xor_byte_shifter u_shifter (
        .iClk        (iClk),
        .iRst        (iRst),
        .flush_i     (timeout),
        .byte_i      (bus.iByte),
        .take_i      (take && (state_q == ST_LOAD)),
        .ready_o     (sh_ready),
        .bit_o       (sh_bit),
        .bit_valid_o (sh_bit_valid),
        .byte_done_o (sh_byte_done)
    );

    // Frame FSM with registered load/busy/done/error outputs.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q    <= ST_IDLE;
            frame_q    <= FRAME_KEY;
            acc_q      <= '0;
            load_key_q <= 1'b0;
            load_msg_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    acc_q <= '0;
                    if (take) begin
                        if (bus.iByte == HDR_KEY) begin
                            state_q    <= ST_LOAD;
                            frame_q    <= FRAME_KEY;
                            load_key_q <= 1'b1;
                            busy_q     <= 1'b1;
                        end else if (bus.iByte == HDR_MSG) begin
                            state_q    <= ST_LOAD;
                            frame_q    <= FRAME_MSG;
                            load_msg_q <= 1'b1;
                            busy_q     <= 1'b1;
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (take) begin
                        acc_q <= acc_q + CW'(1);
                    end
                    if (timeout) begin
                        state_q    <= ST_IDLE;
                        load_key_q <= 1'b0;
                        load_msg_q <= 1'b0;
                        busy_q     <= 1'b0;
                        error_q    <= 1'b1;
                    end else if (frame_last) begin
                        state_q    <= ST_END;
                        load_key_q <= 1'b0;
                        load_msg_q <= 1'b0;
                        done_q     <= 1'b1;
                    end
                end
                ST_END: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    acc_q   <= '0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.oByte_ready = ready;
    assign bus.oSerial_out = sh_bit;
    assign bus.oEn         = sh_bit_valid;
    assign bus.oLoad_key   = load_key_q;
    assign bus.oLoad_msg   = load_msg_q;
    assign bus.oBusy       = busy_q;
    assign bus.oDone       = done_q;
    assign bus.oError      = error_q;

endmodule

// File: tb/tb_xor_load_sequencer.sv
// Bench for xor_load_sequencer: directed frames plus randomized frames,
// observed serial stream compared with the payload bytes fed in.
module tb_xor_load_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    xor_load_sequencer_if bus ();

    xor_load_sequencer #(
        .KEY_BYTES      (4),
        .MSG_BYTES      (64),
        .HDR_KEY        (8'h4B),
        .HDR_MSG        (8'h4D),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .iClk (clk),
        .iRst (rst),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Cycle index, stable when read on the falling edge.
    always @(posedge clk) cyc <= cyc + 1;

    logic       bits_q[$];
    logic [7:0] pl[$];
    int en_cnt, en_runs, done_cnt, err_cnt, busy_cnt, key_cyc, msg_cyc, both_cnt, flag_bad;
    int first_load, last_load, first_en, last_en, done_k, err_k;
    logic prev_en = 1'b0;

    // Observe outputs on the falling edge.
    always @(negedge clk) begin
        if (bus.oEn) begin
            bits_q.push_back(bus.oSerial_out);
            en_cnt++;
            if (first_en < 0) first_en = cyc;
            last_en = cyc;
            if (!prev_en) en_runs++;
            if (!(bus.oLoad_key ^ bus.oLoad_msg)) flag_bad++;
        end
        if (bus.oLoad_key && bus.oLoad_msg) flag_bad++;
        if (bus.oLoad_key || bus.oLoad_msg) begin
            if (first_load < 0) first_load = cyc;
            last_load = cyc;
        end
        if (bus.oLoad_key) key_cyc++;
        if (bus.oLoad_msg) msg_cyc++;
        if (bus.oBusy) busy_cnt++;
        if (bus.oDone) begin done_cnt++; done_k = cyc; end
        if (bus.oError) begin err_cnt++; err_k = cyc; end
        if (bus.oDone && bus.oError) both_cnt++;
        prev_en = bus.oEn;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        @(posedge clk);
        #1;
        bits_q.delete();
        en_cnt = 0; en_runs = 0; done_cnt = 0; err_cnt = 0; busy_cnt = 0;
        key_cyc = 0; msg_cyc = 0; both_cnt = 0; flag_bad = 0;
        first_load = -1; last_load = -1; first_en = -1; last_en = -1;
        done_k = -1; err_k = -1;
    endtask

    // Present a byte after 'gap' idle cycles; returns the cycle it transferred in.
    task automatic drive_byte(input logic [7:0] b, input int gap, output int k);
        int t;
        repeat (gap) begin
            @(negedge clk);
            bus.iByte_valid = 1'b0;
        end
        @(negedge clk);
        bus.iByte       = b;
        bus.iByte_valid = 1'b1;
        t = 0;
        while (!bus.oByte_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check_eq("ready_wait", 32'(bus.oByte_ready), 32'd1);
        k = cyc;
        @(posedge clk);
    endtask

    task automatic release_bus();
        @(negedge clk);
        bus.iByte_valid = 1'b0;
    endtask

    function automatic logic [7:0] got_byte(input int i);
        logic [7:0] v;
        v = 'x;
        if (bits_q.size() >= 8 * (i + 1)) begin
            for (int j = 0; j < 8; j++) v[7 - j] = bits_q[8 * i + j];
        end
        return v;
    endfunction

    // Sends header + pl[] and checks the frame against the payload model.
    task automatic run_frame(input logic is_key, input int gap, input logic rnd_gap);
        int hk, k, n, t, own, other;
        n = pl.size();
        clear_stats();
        drive_byte(is_key ? 8'h4B : 8'h4D, 0, hk);
        foreach (pl[i]) drive_byte(pl[i], rnd_gap ? int'($urandom_range(gap, 0)) : gap, k);
        release_bus();
        t = 0;
        while (done_cnt == 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        own   = is_key ? key_cyc : msg_cyc;
        other = is_key ? msg_cyc : key_cyc;
        check_eq("done_count", done_cnt, 1);
        check_eq("error_count", err_cnt, 0);
        check_eq("done_and_error", both_cnt, 0);
        check_eq("flag_exclusive", flag_bad, 0);
        check_eq("en_count", en_cnt, 8 * n);
        for (int i = 0; i < n; i++) check_eq("data_byte", 32'(got_byte(i)), 32'(pl[i]));
        check_eq("first_load", first_load, hk + 1);
        check_eq("load_continuous", own, last_load - first_load + 1);
        check_eq("other_flag", other, 0);
        check_eq("last_en_in_load", last_en, last_load);
        check_eq("done_cycle", done_k, last_load + 1);
        check_eq("busy_cycles", busy_cnt, last_load - first_load + 2);
        if (gap == 0 && !rnd_gap) begin
            check_eq("first_en", first_en, hk + 2);
            check_eq("load_cycles", own, 1 + 8 * n);
            check_eq("en_runs", en_runs, 1);
        end
    endtask

    task automatic bad_header(input logic [7:0] b);
        int k;
        clear_stats();
        drive_byte(b, 0, k);
        release_bus();
        repeat (4) @(negedge clk);
        check_eq("bad_err_count", err_cnt, 1);
        check_eq("bad_err_cycle", err_k, k + 1);
        check_eq("bad_load", key_cyc + msg_cyc, 0);
        check_eq("bad_busy", busy_cnt, 0);
        check_eq("bad_done", done_cnt, 0);
    endtask

    function automatic logic [31:0] outs();
        return 32'({bus.oByte_ready, bus.oSerial_out, bus.oEn, bus.oLoad_key,
                    bus.oLoad_msg, bus.oBusy, bus.oDone, bus.oError});
    endfunction

    initial begin
        int k, ka, t, kind;
        logic [7:0] b;
        bus.iByte       = 8'h00;
        bus.iByte_valid = 1'b0;
        clear_stats();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outputs", outs(), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Key frame, back-to-back
        pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_frame(1'b1, 0, 1'b0);

        // Message frame with 3-cycle stalls between bytes
        pl.delete();
        for (int i = 0; i < 64; i++) pl.push_back(8'(i));
        run_frame(1'b0, 3, 1'b0);

        // Bad header then a normal key frame
        bad_header(8'h55);
        pl = '{8'(($urandom)), 8'(($urandom)), 8'(($urandom)), 8'(($urandom))};
        run_frame(1'b1, 0, 1'b0);

        // Reset after two of four key bytes
        clear_stats();
        drive_byte(8'h4B, 0, k);
        drive_byte(8'h11, 0, k);
        drive_byte(8'h22, 0, k);
        @(negedge clk);
        bus.iByte_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("midframe_reset_outputs", outs(), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("midframe_reset_no_done", done_cnt, 0);
        pl = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_frame(1'b1, 0, 1'b0);

        // Header values carried as data
        pl = '{8'h4D, 8'h4B, 8'h4D, 8'h4B};
        run_frame(1'b1, 0, 1'b0);

        // Randomized frames
        for (int r = 0; r < 8; r++) begin
            kind = int'($urandom_range(3, 0));
            if (kind == 0) begin
                b = 8'($urandom);
                if (b == 8'h4B || b == 8'h4D) b = 8'h00;
                bad_header(b);
            end else begin
                pl.delete();
                for (int i = 0; i < ((kind == 3) ? 64 : 4); i++) pl.push_back(8'($urandom));
                run_frame(kind != 3, (kind == 1) ? 0 : 2, kind != 1);
            end
        end

        // Host goes idle after one payload byte
        clear_stats();
        drive_byte(8'h4B, 0, k);
        drive_byte(8'hAA, 0, ka);
        release_bus();
`ifdef XOR_LOAD_TIMEOUT_EN
        t = 0;
        while (err_cnt == 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        check_eq("to_en_count", en_cnt, 8);
        check_eq("to_data", 32'(got_byte(0)), 32'hAA);
        check_eq("to_err_count", err_cnt, 1);
        check_eq("to_err_cycle", err_k, ka + 17);
        check_eq("to_last_load", last_load, err_k - 1);
        check_eq("to_done", done_cnt, 0);
        check_eq("to_busy", 32'(bus.oBusy), 32'd0);
        check_eq("to_load_key", 32'(bus.oLoad_key), 32'd0);
`else
        repeat (60) @(negedge clk);
        check_eq("hold_en_count", en_cnt, 8);
        check_eq("hold_data", 32'(got_byte(0)), 32'hAA);
        check_eq("hold_err", err_cnt, 0);
        check_eq("hold_done", done_cnt, 0);
        check_eq("hold_load_key", 32'(bus.oLoad_key), 32'd1);
        check_eq("hold_busy", 32'(bus.oBusy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("hold_reset_outputs", outs(), 32'd0);
        @(negedge clk);
        rst = 1'b0;
`endif
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
